// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: funnels per-execution-unit writeback beats into a single
// register-file write port. Single-beat packets arbitrate round-robin; a
// multi-beat packet (sop without eop) locks the port to its owner until eop.
module vx_wb_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 256,
  localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  output logic [DATAW-1:0]          wb_data,
  output logic                      wb_sop,
  output logic                      wb_eop,
  output logic [SELW-1:0]           wb_sel,
  output logic                      err_sticky
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t               r_state;
  logic [SELW-1:0]      r_owner;
  logic [SELW-1:0]      r_rr_ptr;
  logic                 r_wb_valid;
  logic [DATAW-1:0]     r_wb_data;
  logic                 r_wb_sop;
  logic                 r_wb_eop;
  logic [SELW-1:0]      r_wb_sel;
  logic                 r_err;

  logic                 w_found;
  logic [SELW-1:0]      w_gnt_idx;
  logic [NUM_REQS-1:0]  w_ready;
  logic                 w_fire;
  logic [DATAW-1:0]     w_beat_data;
  logic                 w_sop;
  logic                 w_eop;
  logic [SELW-1:0]      w_next_ptr;
  logic                 w_proto_err;

  // Index arithmetic modulo NUM_REQS (NUM_REQS need not be a power of two).
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                               input int unsigned     off);
    logic [31:0] sum;
    sum = 32'(base) + 32'(off);
    if (sum >= 32'(NUM_REQS)) begin
      sum = sum - 32'(NUM_REQS);
    end else begin
      sum = sum;
    end
    return sum[SELW-1:0];
  endfunction

  // Grant selection: owner while locked, otherwise first valid from rr_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    case (r_state)
      ST_LOCKED: begin
        // The owner holds the port even when it is not valid (bubble).
        w_found   = 1'b1;
        w_gnt_idx = r_owner;
      end
      ST_UNLOCKED: begin
        for (int k = 0; k < NUM_REQS; k++) begin
          if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
            w_found   = 1'b1;
            w_gnt_idx = wrap_add(r_rr_ptr, k);
          end else begin
            w_found   = w_found;
          end
        end
      end
      default: begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
      end
    endcase
  end

  // One-hot ready at the granted index; forced low while reset is asserted.
  always_comb begin
    w_ready = '0;
    if (reset) begin
      w_ready = '0;
    end else if (w_found) begin
      w_ready[w_gnt_idx] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign req_ready   = w_ready;
  assign w_fire      = |(req_valid & w_ready);
  assign w_beat_data = req_data[w_gnt_idx*DATAW +: DATAW];
  assign w_sop       = req_sop[w_gnt_idx];
  assign w_eop       = req_eop[w_gnt_idx];
  assign w_next_ptr  = wrap_add(w_gnt_idx, 1);
  // A packet must open with sop when unlocked and must not re-open while locked.
  assign w_proto_err = ((r_state == ST_UNLOCKED) && !w_sop) ||
                       ((r_state == ST_LOCKED)   &&  w_sop);

  // Lock FSM and round-robin pointer; rr_ptr advances only on eop beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_UNLOCKED;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      if (w_eop) begin
        r_state  <= ST_UNLOCKED;
        r_rr_ptr <= w_next_ptr;
      end else if (w_sop) begin
        r_state  <= ST_LOCKED;
        r_owner  <= w_gnt_idx;
      end else begin
        r_state  <= r_state;
      end
    end else begin
      r_state <= r_state;
    end
  end

  // Writeback register: captures the accepted beat, holds payload on bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_sop   <= 1'b0;
      r_wb_eop   <= 1'b0;
      r_wb_sel   <= '0;
    end else if (w_fire) begin
      r_wb_valid <= 1'b1;
      r_wb_data  <= w_beat_data;
      r_wb_sop   <= w_sop;
      r_wb_eop   <= w_eop;
      r_wb_sel   <= w_gnt_idx;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  // Sticky protocol-error flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_fire && w_proto_err) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign wb_sop     = r_wb_sop;
  assign wb_eop     = r_wb_eop;
  assign wb_sel     = r_wb_sel;
  assign err_sticky = r_err;

endmodule
